huffman_stream_ctrl: RTL and testbench
======================================

# huffman_stream_ctrl

Sequencer and bit packer in front of `huffman_coder`. It accepts ASCII characters over a valid/ready stream and drives the coder's `valid`/`load` handshake, one symbol at a time. It packs each returned variable-length code MSB-first into a continuous bitstream and emits that stream as bytes over a second valid/ready port. A flush request pads the final partial byte with zeros.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles to wait in WAIT_CODE for `coder_valid_out` before aborting the symbol.
- `MAX_LEN`, 10: largest legal code length.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `in_ascii` in 7: character to encode.
- `in_valid` in 1: `in_ascii` is valid.
- `in_ready` out 1: character is accepted when `in_valid && in_ready`.
- `flush` in 1: request to pad and emit the pending partial byte.
- `flush_done` out 1: 1-cycle pulse when the flush has completed.
- `coder_ascii` out 7: registered character sent to the coder.
- `coder_valid` out 1: 1-cycle request to the coder.
- `coder_load` out 1: 1-cycle acknowledge; the coder sees it as a rising edge.
- `coder_code` in 10: Huffman code; bits `[len-1:0]` are used.
- `coder_len` in 4: code length.
- `coder_valid_out` in 1: coder result is ready.
- `out_byte` out 8: packed byte; the first bit of the stream is bit 7.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `err_len` out 1: 1-cycle pulse when a symbol with length 0 or length > MAX_LEN is dropped.
- `err_timeout` out 1: 1-cycle pulse on coder timeout.
- `bits_pending` out 5: number of bits in the accumulator (0..17).

## Operation
- **Reset values:** every output is 0, except `in_ready`, which is 1. The accumulator is cleared and the state is IDLE.
- **IDLE:**
  - `in_ready` = 1 when `bits_pending` < 8 and `flush` is low.
  - Flush has priority. If `flush` and `in_valid` are both high, `in_ready` = 0 and the FSM goes to FLUSH.
  - On an accepted character, latch it into `coder_ascii` and go to REQ.
- **REQ:** `coder_valid` = 1 for one cycle, then go to WAIT_CODE. The timeout counter is cleared.
- **WAIT_CODE:**
  - If `coder_valid_out` is high, sample `coder_code`/`coder_len` and go to ACK.
    - If the length is legal, append `code[len-1:0]` to the accumulator MSB-first; `bits_pending` += len.
    - If the length is illegal, pulse `err_len` and leave the accumulator unchanged.
  - If the counter reaches TIMEOUT, pulse `err_timeout` and go to IDLE. No bits are added and `coder_load` is not pulsed.
- **ACK:** `coder_load` = 1 for one cycle, then go to WAIT_CLR.
- **WAIT_CLR:** stay until `coder_valid_out` = 0, then go to IDLE. This prevents a stale `valid_out` from being read as the next result.
- **FLUSH:**
  - Wait until `bits_pending` < 8 and the output register is free.
  - If `bits_pending` > 0, emit the remaining bits left-aligned and zero-padded, and clear the count.
  - Pulse `flush_done` and go to IDLE.
  - With `bits_pending` = 0, `flush_done` pulses on the FLUSH cycle and no byte is emitted.
- **Byte emission (independent of the FSM):**
  - When `bits_pending` ≥ 8 and (`!out_valid || out_ready`), load the top 8 pending bits into `out_byte`, set `out_valid`, and subtract 8 from `bits_pending`.
  - `out_valid` clears on `out_ready` when no new byte is loaded.
  - `out_byte` holds stable while `out_valid && !out_ready`.
- **Capacity:** characters are only accepted with ≤ 7 pending bits, so the maximum is 7 + 10 = 17 bits. The accumulator is 17 bits wide with no overflow path.
- **Mid-operation reset:** everything returns to reset values and pending bits are discarded. The coder shares `reset`, so both return to idle together.

## Timing
- Character accept at cycle 0. REQ at cycle 1.
- With the codebase coder, `coder_valid_out` rises at cycle 4, ACK is at cycle 5, and `coder_valid_out` falls at cycle 7. IDLE accepts the next character at cycle 8 at the earliest.
- A byte appears on `out_valid` one cycle after `bits_pending` reaches ≥ 8, provided the output register is free.
- Only one symbol is ever in flight.

## Structure
- Package `huffman_pkg`:
  - state enum `ctrl_state_t`: IDLE, REQ, WAIT_CODE, ACK, WAIT_CLR, FLUSH.
  - constants `ASCII_W`=7, `CODE_W`=10, `LEN_W`=4, `ACC_W`=17.
- Sub-module `huffman_bit_packer`: accumulator, bit count, append/flush logic and the output byte register with valid/ready.
- The FSM and timeout counter stay in `huffman_stream_ctrl`.

## Test plan
The bench uses a behavioural coder model with the codebase handshake and a programmable code table.

1. **Reset:** after `reset` is released, all outputs are 0 except `in_ready` = 1, and `bits_pending` = 0.
2. **Byte packing:** codes 101/len3, 0110/len4, 1/len1 → exactly one byte, `out_byte` = 0xAD; `bits_pending` = 0; `coder_load` pulses once per symbol.
3. **Long code plus flush:** code 10'b1111100000/len10, then `flush` → bytes 0xF8 then 0x00; one `flush_done` pulse after the second byte.
4. **Backpressure:** `out_ready` held low while 16 bits of codes arrive → `out_byte` stays stable on the first byte and `in_ready` = 0 while `bits_pending` ≥ 8. On release, the second byte follows on the next cycle.
5. **Timeout:** the model never asserts `valid_out` → `err_timeout` pulses once 16 cycles after REQ; FSM returns to IDLE; `bits_pending` is unchanged; no `coder_load`.
6. **Illegal length:** the model returns len 0 → `err_len` pulse, `coder_load` still pulses, `bits_pending` is unchanged, and the next character encodes normally.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and widths for the Huffman stream controller and its bit packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package huffman_pkg;

   localparam int ASCII_W = 7;
   localparam int CODE_W  = 10;
   localparam int LEN_W   = 4;
   localparam int ACC_W   = 17;
   localparam int CNT_W   = 5;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REQ       = 3'd1,
      WAIT_CODE = 3'd2,
      ACK       = 3'd3,
      WAIT_CLR  = 3'd4,
      FLUSH     = 3'd5
   } ctrl_state_t;

   // A code length is usable only if it is non-zero and fits the code field.
   function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
      return (len != '0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/huffman_bit_packer.sv
// Packs variable-length codes MSB-first into a bit accumulator and emits bytes.
// Latency: a byte is presented one cycle after 8 or more bits are pending.
// Backpressure: out_byte holds while out_valid && !out_ready; bits stay pending.
module huffman_bit_packer
   import huffman_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              append,
   input  logic [CODE_W-1:0] code,
   input  logic [LEN_W-1:0]  len,
   input  logic              flush_emit,
   output logic              flush_ok,
   output logic [7:0]        out_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  bits_pending
);

   // Valid bits live right-aligned in acc[bits_pending-1:0]; the oldest bit is the
   // highest of them. Bits above that window are stale and are never read.
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] code_mask;
   logic [CNT_W-1:0] cnt_nxt;
   logic [7:0]       byte_nxt;
   logic             out_free;
   logic             full_emit;
   logic             part_emit;

   assign out_free  = !out_valid || out_ready;
   assign full_emit = (bits_pending >= CNT_W'(8)) && out_free;
   assign part_emit = flush_emit && (bits_pending != '0);
   assign flush_ok  = (bits_pending < CNT_W'(8)) && out_free;
   assign code_mask = (ACC_W'(1) << len) - ACC_W'(1);

   // Next accumulator/count: remove an emitted byte, then append the new code.
   always_comb begin
      cnt_nxt = bits_pending;
      acc_nxt = acc;
      if (full_emit)
         cnt_nxt = bits_pending - CNT_W'(8);
      if (part_emit)
         cnt_nxt = '0;
      if (append) begin
         cnt_nxt = cnt_nxt + CNT_W'(len);
         acc_nxt = (acc << len) | (ACC_W'(code) & code_mask);
      end
   end

   // Byte to emit: top 8 pending bits, or the short remainder left-aligned with zero fill.
   always_comb begin
      if (part_emit)
         byte_nxt = 8'(acc << (CNT_W'(8) - bits_pending));
      else
         byte_nxt = 8'(acc >> (bits_pending - CNT_W'(8)));
   end

   // Accumulator and pending-bit count.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc          <= '0;
         bits_pending <= '0;
      end else begin
         acc          <= acc_nxt;
         bits_pending <= cnt_nxt;
      end
   end

   // Output byte register with valid/ready hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_byte  <= '0;
         out_valid <= 1'b0;
      end else if (full_emit || part_emit) begin
         out_byte  <= byte_nxt;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/huffman_stream_ctrl.sv
// Sequences characters through the Huffman coder and packs the codes into bytes.
// Latency: accept at cycle 0, coder request at 1, next accept at cycle 8 at the earliest.
// Backpressure: in_ready drops while a symbol is in flight or 8+ bits are pending.
module huffman_stream_ctrl
   import huffman_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int MAX_LEN = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ASCII_W-1:0] in_ascii,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic               flush_done,
   output logic [ASCII_W-1:0] coder_ascii,
   output logic               coder_valid,
   output logic               coder_load,
   input  logic [CODE_W-1:0]  coder_code,
   input  logic [LEN_W-1:0]   coder_len,
   input  logic               coder_valid_out,
   output logic [7:0]         out_byte,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               err_len,
   output logic               err_timeout,
   output logic [CNT_W-1:0]   bits_pending
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);

   ctrl_state_t      state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   logic             legal;
   logic             append;
   logic             flush_ok;
   logic             flush_emit;

   assign legal       = len_legal(coder_len, MAX_LEN);
   assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign in_ready    = (state == IDLE) && (bits_pending < CNT_W'(8)) && !flush;
   assign coder_valid = (state == REQ);
   assign coder_load  = (state == ACK);
   assign append      = (state == WAIT_CODE) && coder_valid_out && legal;
   assign err_len     = (state == WAIT_CODE) && coder_valid_out && !legal;
   assign err_timeout = (state == WAIT_CODE) && !coder_valid_out && tmo_hit;
   assign flush_emit  = (state == FLUSH) && flush_ok;
   assign flush_done  = flush_emit;

   // Symbol sequencer: one character in flight, coder handshake, flush handling.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         coder_ascii <= '0;
         tmo_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (flush)
                  state <= FLUSH;
               else if (in_valid && in_ready) begin
                  coder_ascii <= in_ascii;
                  state       <= REQ;
               end
            end
            REQ: begin
               tmo_cnt <= '0;
               state   <= WAIT_CODE;
            end
            WAIT_CODE: begin
               if (coder_valid_out)
                  state <= ACK;
               else if (tmo_hit)
                  state <= IDLE;
               else
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            ACK:      state <= WAIT_CLR;
            // Hold off until the coder drops valid_out so it is not reread as a new result.
            WAIT_CLR: if (!coder_valid_out) state <= IDLE;
            FLUSH:    if (flush_ok) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   huffman_bit_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .append       (append),
      .code         (coder_code),
      .len          (coder_len),
      .flush_emit   (flush_emit),
      .flush_ok     (flush_ok),
      .out_byte     (out_byte),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .bits_pending (bits_pending)
   );

endmodule

// File: tb/tb_huffman_stream_ctrl.sv
// Directed self-checking bench for huffman_stream_ctrl with a behavioural coder model.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low.
module tb_huffman_stream_ctrl;
   import huffman_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic [ASCII_W-1:0] in_ascii;
   logic               in_valid;
   logic               in_ready;
   logic               flush;
   logic               flush_done;
   logic [ASCII_W-1:0] coder_ascii;
   logic               coder_valid;
   logic               coder_load;
   logic [CODE_W-1:0]  coder_code;
   logic [LEN_W-1:0]   coder_len;
   logic               coder_valid_out;
   logic [7:0]         out_byte;
   logic               out_valid;
   logic               out_ready;
   logic               err_len;
   logic               err_timeout;
   logic [CNT_W-1:0]   bits_pending;

   huffman_stream_ctrl #(.TIMEOUT(16), .MAX_LEN(10)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_ascii        (in_ascii),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .flush           (flush),
      .flush_done      (flush_done),
      .coder_ascii     (coder_ascii),
      .coder_valid     (coder_valid),
      .coder_load      (coder_load),
      .coder_code      (coder_code),
      .coder_len       (coder_len),
      .coder_valid_out (coder_valid_out),
      .out_byte        (out_byte),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .err_len         (err_len),
      .err_timeout     (err_timeout),
      .bits_pending    (bits_pending)
   );

   // Coder model: valid_out rises 3 cycles after the request, falls 2 cycles after load.
   logic [1:0]        m_st;
   int                m_cnt;
   logic [CODE_W-1:0] m_code;
   logic [LEN_W-1:0]  m_len;
   logic              m_silent;

   always @(posedge clk) begin
      if (reset) begin
         m_st <= 2'd0; m_cnt <= 0;
         coder_valid_out <= 1'b0; coder_code <= '0; coder_len <= '0;
      end else begin
         case (m_st)
            2'd0: if (coder_valid && !m_silent) begin m_st <= 2'd1; m_cnt <= 0; end
            2'd1: begin
               if (m_cnt == 1) begin
                  coder_valid_out <= 1'b1; coder_code <= m_code; coder_len <= m_len;
                  m_st <= 2'd2;
               end else m_cnt <= m_cnt + 1;
            end
            2'd2: if (coder_load) m_st <= 2'd3;
            default: begin coder_valid_out <= 1'b0; m_st <= 2'd0; end
         endcase
      end
   end

   // Monitor, sampled on the falling edge.
   int         cyc = 0;
   int         n_load = 0, n_errlen = 0, n_errtmo = 0, n_flush = 0;
   int         req_cyc = 0, tmo_cyc = 0;
   logic [7:0] got[$];

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (out_valid && out_ready) got.push_back(out_byte);
         if (coder_load)  n_load++;
         if (err_len)     n_errlen++;
         if (err_timeout) begin n_errtmo++; tmo_cyc = cyc; end
         if (flush_done)  n_flush++;
         if (coder_valid) req_cyc = cyc;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_chk++;
      if (got_v !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic send_sym(input logic [6:0] a, input logic [9:0] c, input logic [3:0] l,
                           input int settle);
      bit ok;
      ok = 1'b0;
      m_code = c; m_len = l;
      in_ascii = a; in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0; ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      chk("accept", 32'(ok), 32'd1);
      if (ok) chk("coder_ascii", 32'(coder_ascii), 32'(a));
      tick(settle);
   endtask

   task automatic do_flush();
      bit ok;
      ok = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (flush_done) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_seen", 32'(ok), 32'd1);
      tick(3);
   endtask

   initial begin
      int ld0, el0, et0, fl0;
      reset = 1'b1; in_ascii = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      m_code = '0; m_len = '0; m_silent = 1'b0;

      // 1. Reset state
      do_reset();
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_outs", {20'd0, coder_valid, coder_load, out_valid, err_len, err_timeout,
                       flush_done, coder_ascii != 7'd0, out_byte != 8'd0, 4'd0}, 32'd0);
      chk("rst_pending", 32'(bits_pending), 32'd0);
      tick(1);

      // 2. Packing 101 + 0110 + 1 -> 0xAD
      got.delete(); ld0 = n_load;
      send_sym(7'h41, 10'b101,  4'd3, 10);
      send_sym(7'h42, 10'b0110, 4'd4, 10);
      send_sym(7'h43, 10'b1,    4'd1, 10);
      chk("pack_nbytes", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("pack_byte", 32'(got[0]), 32'hAD);
      chk("pack_pending", 32'(bits_pending), 32'd0);
      chk("pack_loads", 32'(n_load - ld0), 32'd3);

      // 3. Long code then flush -> 0xF8, 0x00
      got.delete(); fl0 = n_flush;
      send_sym(7'h44, 10'b1111100000, 4'd10, 10);
      chk("long_pending", 32'(bits_pending), 32'd2);
      do_flush();
      chk("flush_nbytes", 32'(got.size()), 32'd2);
      if (got.size() > 1) begin
         chk("flush_b0", 32'(got[0]), 32'hF8);
         chk("flush_b1", 32'(got[1]), 32'h00);
      end
      chk("flush_pulses", 32'(n_flush - fl0), 32'd1);
      chk("flush_pending", 32'(bits_pending), 32'd0);

      // Flush with nothing pending: pulse but no byte
      got.delete(); fl0 = n_flush;
      do_flush();
      chk("flush0_pulses", 32'(n_flush - fl0), 32'd1);
      chk("flush0_nbytes", 32'(got.size()), 32'd0);

      // 4. Backpressure: 1010 0101 -> 0xA5, 1100 0011 -> 0xC3
      got.delete();
      out_ready = 1'b0;
      send_sym(7'h45, 10'b1010, 4'd4, 10);
      send_sym(7'h46, 10'b0101, 4'd4, 10);
      send_sym(7'h47, 10'b1100, 4'd4, 10);
      send_sym(7'h48, 10'b0011, 4'd4, 10);
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_byte", 32'(out_byte), 32'hA5);
      chk("bp_pending", 32'(bits_pending), 32'd8);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick(3);
      @(negedge clk);
      chk("bp_hold", 32'(out_byte), 32'hA5);
      chk("bp_nohs", 32'(got.size()), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel0", 32'(out_byte), 32'hA5);
      @(negedge clk);
      chk("bp_rel1_byte", 32'(out_byte), 32'hC3);
      chk("bp_rel1_valid", 32'(out_valid), 32'd1);
      tick(3);
      chk("bp_nbytes", 32'(got.size()), 32'd2);
      if (got.size() > 1) chk("bp_order", {16'd0, got[0], got[1]}, 32'hA5C3);
      chk("bp_pending_end", 32'(bits_pending), 32'd0);

      // 5. Timeout with 3 bits pending
      send_sym(7'h49, 10'b111, 4'd3, 10);
      ld0 = n_load; et0 = n_errtmo;
      m_silent = 1'b1;
      send_sym(7'h4A, 10'b0, 4'd5, 25);
      m_silent = 1'b0;
      chk("tmo_pulses", 32'(n_errtmo - et0), 32'd1);
      chk("tmo_delay", 32'(tmo_cyc - req_cyc), 32'd16);
      chk("tmo_noload", 32'(n_load - ld0), 32'd0);
      chk("tmo_pending", 32'(bits_pending), 32'd3);
      chk("tmo_idle", 32'(in_ready), 32'd1);

      // 6. Illegal lengths 0 and 11, then a normal symbol 10110 -> 111_10110 = 0xF6
      got.delete(); ld0 = n_load; el0 = n_errlen;
      send_sym(7'h4B, 10'h3FF, 4'd0, 10);
      chk("len0_err", 32'(n_errlen - el0), 32'd1);
      chk("len0_load", 32'(n_load - ld0), 32'd1);
      chk("len0_pending", 32'(bits_pending), 32'd3);
      send_sym(7'h4C, 10'h3FF, 4'd11, 10);
      chk("len11_err", 32'(n_errlen - el0), 32'd2);
      chk("len11_pending", 32'(bits_pending), 32'd3);
      send_sym(7'h4D, 10'b10110, 4'd5, 10);
      chk("after_err_nbytes", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("after_err_byte", 32'(got[0]), 32'hF6);
      chk("after_err_pending", 32'(bits_pending), 32'd0);

      // Mid-operation reset discards pending bits
      send_sym(7'h4E, 10'b101, 4'd3, 10);
      chk("pre_rst_pending", 32'(bits_pending), 32'd3);
      do_reset();
      @(negedge clk);
      chk("mid_rst_pending", 32'(bits_pending), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
